// File: rtl/multi_timer_pkg.sv
// Shared register map, channel control layout and channel types for multi_timer.
package multi_timer_pkg;

  localparam logic [11:0] OffCtrl      = 12'h000;
  localparam logic [11:0] OffPrescale  = 12'h004;
  localparam logic [11:0] OffIrqStatus = 12'h008;
  localparam logic [11:0] OffIrqEn     = 12'h00C;

  // Channel n lives at ChBase + n * ChStride; the index is addr[11:ChStrideLog2] after rebasing.
  localparam logic [11:0]  ChBase       = 12'h100;
  localparam int unsigned  ChStrideLog2 = 4;
  localparam logic [11:0]  ChStride     = 12'(1 << ChStrideLog2);

  localparam logic [3:0] ChOffLoad  = 4'h0;
  localparam logic [3:0] ChOffValue = 4'h4;
  localparam logic [3:0] ChOffCctrl = 4'h8;
  localparam logic [3:0] ChOffRsvd  = 4'hC;

  localparam int unsigned CctrlCenBit      = 0;
  localparam int unsigned CctrlPeriodicBit = 1;

  typedef struct packed {
    logic periodic;
    logic cen;
  } cctrl_t;

  typedef enum logic {
    ChIdle = 1'b0,
    ChRun  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/multi_timer_channel.sv
// One countdown channel: reload register, run/idle FSM and expiry pulse on prescaler ticks.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 load_we_i,
  input  logic                 ctrl_we_i,
  input  logic [DataWidth-1:0] load_wdata_i,
  input  cctrl_t               ctrl_wdata_i,
  output logic [DataWidth-1:0] load_o,
  output logic [DataWidth-1:0] value_o,
  output cctrl_t               cctrl_o,
  output logic                 expire_c_o
);

  ch_state_e            state_q, state_d;
  logic [DataWidth-1:0] value_q, value_d;
  logic [DataWidth-1:0] load_q, load_d;
  logic                 periodic_q, periodic_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ChIdle;
      value_q    <= '0;
      load_q     <= '0;
      periodic_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      load_q     <= load_d;
      periodic_q <= periodic_d;
    end
  end

  // A CCTRL write pre-empts a tick in the same cycle; LOAD writes only affect later reloads.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    load_d     = load_q;
    periodic_d = periodic_q;
    expire_c_o = 1'b0;

    if (load_we_i) begin
      load_d = load_wdata_i;
    end

    if (ctrl_we_i) begin
      periodic_d = ctrl_wdata_i.periodic;
      if (ctrl_wdata_i.cen) begin
        state_d = ChRun;
        value_d = load_q;
      end else begin
        state_d = ChIdle;
      end
    end else if (tick_i && (state_q == ChRun)) begin
      if (value_q > DataWidth'(1)) begin
        value_d = value_q - DataWidth'(1);
      end else if (value_q == DataWidth'(1)) begin
        expire_c_o = 1'b1;
        if (periodic_q) begin
          value_d = load_q;
        end else begin
          value_d = '0;
          state_d = ChIdle;
        end
      end else if (!periodic_q) begin
        state_d = ChIdle;
      end
    end
  end

  assign load_o           = load_q;
  assign value_o          = value_q;
  assign cctrl_o.periodic = periodic_q;
  assign cctrl_o.cen      = (state_q == ChRun);

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer: device-bus register file, shared prescaler and merged interrupts.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned PrescWidth   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [3:0]              device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic                    irq_o,
  output logic [NumChannels-1:0]  irq_ch_o
);

  localparam int unsigned NumBytes = DataWidth / 8;

  function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] old_v,
                                                    input logic [DataWidth-1:0] new_v,
                                                    input logic [DataWidth-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [11:0] off_w, ch_rel_w;
  logic [7:0]  ch_idx;
  logic [3:0]  ch_reg;
  logic        is_global, global_hit, ch_hit, wr_en, prescale_we;
  logic [DataWidth-1:0] be_mask;

  assign off_w      = {device_addr_i[11:2], 2'b00};
  assign ch_rel_w   = off_w - ChBase;
  assign ch_idx     = ch_rel_w[11:ChStrideLog2];
  assign ch_reg     = ch_rel_w[ChStrideLog2-1:0];
  assign is_global  = (off_w < ChBase);
  assign global_hit = is_global && ((off_w == OffCtrl) || (off_w == OffPrescale) ||
                                    (off_w == OffIrqStatus) || (off_w == OffIrqEn));
  assign ch_hit     = !is_global && (32'(ch_idx) < NumChannels) && (ch_reg != ChOffRsvd);
  assign wr_en      = device_req_i && device_we_i;
  assign prescale_we = wr_en && global_hit && (off_w == OffPrescale);

  logic unused_addr;
  assign unused_addr = ^{device_addr_i[AddressWidth-1:12], device_addr_i[1:0]};

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NumBytes; b++) begin
      be_mask[8*b +: 8] = {8{device_be_i[b % 4]}};
    end
  end

  logic                   ctrl_en_q, ctrl_en_d;
  logic [PrescWidth-1:0]  prescale_q, prescale_d;
  logic [PrescWidth-1:0]  presc_cnt_q, presc_cnt_d;
  logic [NumChannels-1:0] irq_status_q, irq_status_d;
  logic [NumChannels-1:0] irq_en_q, irq_en_d;
  logic [NumChannels-1:0] w1c;
  logic                   rvalid_q, err_q;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   tick;

  logic [DataWidth-1:0]   ch_load  [NumChannels];
  logic [DataWidth-1:0]   ch_value [NumChannels];
  cctrl_t                 ch_cctrl [NumChannels];
  logic [NumChannels-1:0] ch_expire;

  assign tick = ctrl_en_q && (presc_cnt_q == prescale_q);

  for (genvar n = 0; n < NumChannels; n++) begin : g_ch
    logic                 ch_sel;
    logic [DataWidth-1:0] load_wdata;

    assign ch_sel     = ch_hit && (ch_idx == 8'(n));
    assign load_wdata = be_merge(ch_load[n], device_wdata_i, be_mask);

    multi_timer_channel #(
      .DataWidth(DataWidth)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tick_i      (tick),
      .load_we_i   (wr_en && ch_sel && (ch_reg == ChOffLoad)),
      .ctrl_we_i   (wr_en && ch_sel && (ch_reg == ChOffCctrl) && device_be_i[0]),
      .load_wdata_i(load_wdata),
      .ctrl_wdata_i(cctrl_t'(device_wdata_i[1:0])),
      .load_o      (ch_load[n]),
      .value_o     (ch_value[n]),
      .cctrl_o     (ch_cctrl[n]),
      .expire_c_o  (ch_expire[n])
    );
  end

  // Global register writes; a channel expiry beats a W1C of the same bit.
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    prescale_d = prescale_q;
    irq_en_d   = irq_en_q;
    w1c        = '0;
    if (wr_en && global_hit) begin
      case (off_w)
        OffCtrl:      if (device_be_i[0]) ctrl_en_d = device_wdata_i[0];
        OffPrescale:  prescale_d = PrescWidth'(be_merge(DataWidth'(prescale_q), device_wdata_i, be_mask));
        OffIrqStatus: w1c = NumChannels'(device_wdata_i & be_mask);
        OffIrqEn:     irq_en_d = NumChannels'(be_merge(DataWidth'(irq_en_q), device_wdata_i, be_mask));
        default:      ;
      endcase
    end
    irq_status_d = (irq_status_q & ~w1c) | ch_expire;

    presc_cnt_d = presc_cnt_q + PrescWidth'(1);
    if (!ctrl_en_q || tick || prescale_we) begin
      presc_cnt_d = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (global_hit) begin
      case (off_w)
        OffCtrl:      rdata_d = DataWidth'(ctrl_en_q);
        OffPrescale:  rdata_d = DataWidth'(prescale_q);
        OffIrqStatus: rdata_d = DataWidth'(irq_status_q);
        OffIrqEn:     rdata_d = DataWidth'(irq_en_q);
        default:      rdata_d = '0;
      endcase
    end else if (ch_hit) begin
      for (int n = 0; n < NumChannels; n++) begin
        if (ch_idx == 8'(n)) begin
          case (ch_reg)
            ChOffLoad:  rdata_d = ch_load[n];
            ChOffValue: rdata_d = ch_value[n];
            ChOffCctrl: rdata_d = DataWidth'(ch_cctrl[n]);
            default:    rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en_q    <= 1'b0;
      prescale_q   <= '0;
      presc_cnt_q  <= '0;
      irq_status_q <= '0;
      irq_en_q     <= '0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ctrl_en_q    <= ctrl_en_d;
      prescale_q   <= prescale_d;
      presc_cnt_q  <= presc_cnt_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
      rvalid_q     <= device_req_i;
      err_q        <= device_req_i && !(global_hit || ch_hit);
      rdata_q      <= (device_req_i && !device_we_i) ? rdata_d : '0;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_err_o    = err_q;
  assign device_rdata_o  = rdata_q;
  assign irq_ch_o        = irq_status_q & irq_en_q;
  assign irq_o           = |irq_ch_o;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: bus responses checked against queued expectations.
module tb_multi_timer;

  localparam int unsigned NumChannels  = 4;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AddressWidth = 32;
  localparam int unsigned PrescWidth   = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    req = 1'b0;
  logic [AddressWidth-1:0] addr = '0;
  logic                    we = 1'b0;
  logic [3:0]              be = '0;
  logic [DataWidth-1:0]    wdata = '0;
  logic                    rvalid;
  logic [DataWidth-1:0]    rdata;
  logic                    err;
  logic                    irq;
  logic [NumChannels-1:0]  irq_ch;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];
  string       exp_name_q[$];

  multi_timer #(
    .NumChannels (NumChannels),
    .DataWidth   (DataWidth),
    .AddressWidth(AddressWidth),
    .PrescWidth  (PrescWidth)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .device_err_o   (err),
    .irq_o          (irq),
    .irq_ch_o       (irq_ch)
  );

  always #5 clk = ~clk;

  // Response monitor: every rvalid pops one queued expectation.
  always @(negedge clk) begin : mon
    logic [31:0] ed;
    logic        ee;
    string       nm;
    if (!rst && rvalid) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h, want no response", rdata);
      end else begin
        ed = exp_data_q.pop_front();
        ee = exp_err_q.pop_front();
        nm = exp_name_q.pop_front();
        if (rdata !== ed || err !== ee) begin
          errors++;
          $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b", nm, rdata, err, ed, ee);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic flush_q();
    exp_data_q.delete();
    exp_err_q.delete();
    exp_name_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                           input logic exp_err, input string name);
    req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    exp_data_q.push_back(32'h0);
    exp_err_q.push_back(exp_err);
    exp_name_q.push_back(name);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err,
                          input string name);
    req = 1'b1; we = 1'b0; addr = a; be = '0;
    exp_data_q.push_back(exp_d);
    exp_err_q.push_back(exp_err);
    exp_name_q.push_back(name);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic apply_reset();
    idle(1);
    rst = 1'b1;
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    #1;
    flush_q();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== '0 || irq !== 1'b0 || irq_ch !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid=%b err=%b rdata=%h irq=%b irq_ch=%b, want all 0",
               rvalid, err, rdata, irq, irq_ch);
    end
    rst = 1'b0;
    bus_read(32'h000, 32'h0, 1'b0, "rst_ctrl");
    bus_read(32'h004, 32'h0, 1'b0, "rst_prescale");
    bus_read(32'h008, 32'h0, 1'b0, "rst_irq_status");
    bus_read(32'h00C, 32'h0, 1'b0, "rst_irq_en");
    bus_read(32'h100, 32'h0, 1'b0, "rst_ch0_load");
    bus_read(32'h104, 32'h0, 1'b0, "rst_ch0_value");
    bus_read(32'h138, 32'h0, 1'b0, "rst_ch3_cctrl");
  endtask

  task automatic test_oneshot();
    int cyc;
    apply_reset();
    bus_write(32'h004, 32'd3, 4'hF, 1'b0, "os_wr_presc");
    bus_write(32'h100, 32'd5, 4'hF, 1'b0, "os_wr_load");
    bus_write(32'h00C, 32'd1, 4'hF, 1'b0, "os_wr_irq_en");
    bus_write(32'h108, 32'd1, 4'hF, 1'b0, "os_wr_cctrl");
    bus_write(32'h000, 32'd1, 4'hF, 1'b0, "os_wr_ctrl");
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (irq === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc != 20) begin
      errors++;
      $display("FAIL oneshot_latency: got irq after %0d cycles, want 20", cyc);
    end
    checks++;
    if (irq_ch !== 4'b0001) begin
      errors++;
      $display("FAIL oneshot_irq_ch: got %b, want 0001", irq_ch);
    end
    bus_read(32'h008, 32'h1, 1'b0, "os_irq_status");
    bus_read(32'h104, 32'h0, 1'b0, "os_value_zero");
    bus_read(32'h108, 32'h0, 1'b0, "os_cen_cleared");
    bus_write(32'h008, 32'h1, 4'hF, 1'b0, "os_w1c");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_w1c_irq: got irq=%b, want 0", irq);
    end
    bus_read(32'h008, 32'h0, 1'b0, "os_irq_status_cleared");
  endtask

  task automatic test_periodic();
    apply_reset();
    bus_write(32'h00C, 32'd2, 4'hF, 1'b0, "per_wr_irq_en");
    bus_write(32'h110, 32'd2, 4'hF, 1'b0, "per_wr_load");
    bus_write(32'h000, 32'd1, 4'hF, 1'b0, "per_wr_ctrl");
    bus_write(32'h118, 32'd3, 4'hF, 1'b0, "per_wr_cctrl");
    bus_read(32'h114, 32'd2, 1'b0, "per_value0");
    bus_read(32'h114, 32'd1, 1'b0, "per_value1");
    bus_read(32'h114, 32'd2, 1'b0, "per_value2");
    bus_read(32'h114, 32'd1, 1'b0, "per_value3");
    checks++;
    if (irq_ch !== 4'b0010) begin
      errors++;
      $display("FAIL per_irq_set: got irq_ch=%b, want 0010", irq_ch);
    end
    idle(1);
    bus_write(32'h008, 32'h2, 4'hF, 1'b0, "per_w1c_on_expiry");
    checks++;
    if (irq_ch !== 4'b0010) begin
      errors++;
      $display("FAIL per_set_wins: got irq_ch=%b, want 0010", irq_ch);
    end
    bus_write(32'h008, 32'h2, 4'hF, 1'b0, "per_w1c_off_expiry");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL per_w1c_clear: got irq=%b, want 0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL per_reexpire: got irq=%b, want 1", irq);
    end
  endtask

  task automatic test_bus();
    apply_reset();
    bus_read(32'h10C, 32'h0, 1'b1, "bus_rd_ch0_rsvd");
    bus_read(32'h010, 32'h0, 1'b1, "bus_rd_global_gap");
    bus_write(32'h100, 32'hAABBCCDD, 4'b0001, 1'b0, "bus_wr_load_be1");
    bus_read(32'h100, 32'h000000DD, 1'b0, "bus_load_be1");
    bus_write(32'h100, 32'h11223344, 4'b1100, 1'b0, "bus_wr_load_be12");
    bus_read(32'h100, 32'h112200DD, 1'b0, "bus_load_be12");
    bus_read(32'h140, 32'h0, 1'b1, "bus_rd_ch4");
    bus_write(32'h140, 32'hFFFFFFFF, 4'hF, 1'b1, "bus_wr_ch4");
    bus_read(32'h100, 32'h112200DD, 1'b0, "bus_ch0_untouched");
    bus_read(32'h130, 32'h0, 1'b0, "bus_ch3_untouched");
    bus_write(32'h104, 32'h12345678, 4'hF, 1'b0, "bus_wr_value_ro");
    bus_read(32'h104, 32'h0, 1'b0, "bus_value_ro");
    bus_write(32'h004, 32'h12345678, 4'b0011, 1'b0, "bus_wr_presc");
    bus_read(32'h004, 32'h00005678, 1'b0, "bus_presc");
    bus_write(32'h00C, 32'hFFFFFFFF, 4'hF, 1'b0, "bus_wr_irq_en");
    bus_read(32'h00C, 32'h0000000F, 1'b0, "bus_irq_en_width");
    bus_read(32'hFF0, 32'h0, 1'b1, "bus_rd_top_window");
    bus_read(32'h10000100, 32'h112200DD, 1'b0, "bus_addr_alias");
  endtask

  task automatic test_collision();
    apply_reset();
    bus_write(32'h004, 32'd3, 4'hF, 1'b0, "col_wr_presc");
    bus_write(32'h100, 32'd7, 4'hF, 1'b0, "col_wr_load");
    bus_write(32'h000, 32'd1, 4'hF, 1'b0, "col_wr_ctrl");
    idle(3);
    bus_write(32'h108, 32'd1, 4'hF, 1'b0, "col_wr_cctrl_on_tick");
    bus_read(32'h104, 32'd7, 1'b0, "col_value_after_tick");
    idle(3);
    bus_read(32'h104, 32'd6, 1'b0, "col_value_next_tick");
  endtask

  task automatic test_freeze();
    logic bad;
    apply_reset();
    bus_write(32'h004, 32'd3, 4'hF, 1'b0, "frz_wr_presc");
    bus_write(32'h100, 32'd6, 4'hF, 1'b0, "frz_wr_load");
    bus_write(32'h00C, 32'd1, 4'hF, 1'b0, "frz_wr_irq_en");
    bus_write(32'h108, 32'd1, 4'hF, 1'b0, "frz_wr_cctrl");
    bus_write(32'h000, 32'd1, 4'hF, 1'b0, "frz_wr_en");
    idle(8);
    bus_write(32'h000, 32'd0, 4'hF, 1'b0, "frz_wr_dis");
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (irq !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL frz_no_irq: got irq during freeze, want none");
    end
    bus_read(32'h104, 32'd4, 1'b0, "frz_value_held");
    bus_write(32'h000, 32'd1, 4'hF, 1'b0, "frz_wr_reen");
    idle(3);
    bus_read(32'h104, 32'd4, 1'b0, "frz_value_before_tick");
    bus_read(32'h104, 32'd3, 1'b0, "frz_value_first_dec");
  endtask

  task automatic test_reset_midcount();
    apply_reset();
    bus_write(32'h00C, 32'd3, 4'hF, 1'b0, "rm_wr_irq_en");
    bus_write(32'h110, 32'd1, 4'hF, 1'b0, "rm_wr_ch1_load");
    bus_write(32'h118, 32'd1, 4'hF, 1'b0, "rm_wr_ch1_cctrl");
    bus_write(32'h000, 32'd1, 4'hF, 1'b0, "rm_wr_ctrl");
    bus_write(32'h004, 32'd1000, 4'hF, 1'b0, "rm_wr_presc");
    bus_write(32'h100, 32'd3, 4'hF, 1'b0, "rm_wr_ch0_load");
    bus_write(32'h108, 32'd1, 4'hF, 1'b0, "rm_wr_ch0_cctrl");
    bus_read(32'h104, 32'd3, 1'b0, "rm_value_before");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL rm_irq_before: got irq=%b, want 1", irq);
    end
    bus_write(32'h100, 32'd3, 4'hF, 1'b0, "rm_wr_pending");
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rm_rvalid_pending: got rvalid=%b, want 1", rvalid);
    end
    rst = 1'b1;
    #1;
    flush_q();
    checks++;
    if (rvalid !== 1'b0 || irq !== 1'b0 || irq_ch !== '0) begin
      errors++;
      $display("FAIL rm_async_clear: got rvalid=%b irq=%b irq_ch=%b, want 0 0 0000", rvalid, irq, irq_ch);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_read(32'h104, 32'h0, 1'b0, "rm_value_after");
    bus_read(32'h108, 32'h0, 1'b0, "rm_cctrl_after");
    bus_read(32'h008, 32'h0, 1'b0, "rm_irq_status_after");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_bus();
    test_collision();
    test_freeze();
    test_reset_midcount();
    idle(2);
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: got %0d unanswered requests, want 0", exp_data_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
